// File: rtl/pe_mac_sequencer.sv
// -----------------------------------------------------------------------------
// pe_mac_sequencer
// Sequences the PE's shared unsigned multiplier through one 1-D convolution
// row. It walks the filter and ifmap scratchpads tap by tap, feeds each operand
// pair to the multiplier, accumulates the products onto an incoming partial
// sum, and returns the finished psum over a valid/ready handshake.
//
// Optional feature macro: PE_ZERO_GATE_EN
//   When defined, accumulate cycles whose ifmap operand is zero are gated:
//   the operands are forced to 0, the accumulator is not written and
//   zero_skips counts the skipped taps (saturating). When undefined, no
//   gating takes place and zero_skips is tied to 0.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 one-cycle request, honoured only while idle
//   filt_len              number of taps n (sampled on accepted start)
//   ifmap_base            ifmap start address (sampled on accepted start)
//   psum_in               initial accumulator value (sampled on accepted start)
//   busy                  high whenever the sequencer is not idle
//   filt_rd_en/addr       filter spad read strobe / address
//   ifmap_rd_en/addr      ifmap spad read strobe / address (wraps)
//   filt_data/ifmap_data  spad read data, valid one cycle after the strobe
//   mult_in1/mult_in2     multiplier operands (filter, ifmap)
//   mult_out              combinational multiplier product
//   psum_out/psum_valid   registered result and its valid flag
//   psum_ready            consumer accepts psum_out
//   zero_skips            gated taps in the current/last row
// -----------------------------------------------------------------------------
module pe_mac_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 20,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   filt_len,
    input  logic [ADDR_WIDTH-1:0]   ifmap_base,
    input  logic [PSUM_WIDTH-1:0]   psum_in,
    output logic                    busy,
    output logic                    filt_rd_en,
    output logic                    ifmap_rd_en,
    output logic [ADDR_WIDTH-1:0]   filt_addr,
    output logic [ADDR_WIDTH-1:0]   ifmap_addr,
    input  logic [DATA_WIDTH-1:0]   filt_data,
    input  logic [DATA_WIDTH-1:0]   ifmap_data,
    output logic [DATA_WIDTH-1:0]   mult_in1,
    output logic [DATA_WIDTH-1:0]   mult_in2,
    input  logic [2*DATA_WIDTH-1:0] mult_out,
    output logic [PSUM_WIDTH-1:0]   psum_out,
    output logic                    psum_valid,
    input  logic                    psum_ready,
    output logic [ADDR_WIDTH-1:0]   zero_skips
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [PSUM_WIDTH-1:0] PSUM_ZERO = {PSUM_WIDTH{1'b0}};

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   n_len;
    logic [ADDR_WIDTH-1:0]   tap;
    logic [PSUM_WIDTH-1:0]   acc;

    logic                    last_tap;
    logic                    acc_cycle;
    logic                    gate;
    logic                    acc_write;
    logic [PSUM_WIDTH-1:0]   acc_next;

    assign last_tap = (tap == (n_len - ADDR_ONE));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (filt_len != ADDR_ZERO) ? RUN : DONE;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (last_tap) begin
                    next_state = DRAIN;
                end else begin
                    next_state = RUN;
                end
            end
            DRAIN: begin
                next_state = DONE;
            end
            DONE: begin
                if (psum_valid && psum_ready) begin
                    next_state = IDLE;
                end else begin
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Accumulate-cycle decode, zero gating and multiplier operand drive.
    // Data read on tap k arrives one cycle later, so the accumulate step lags
    // the read by one cycle: RUN taps 1..n-1 plus the DRAIN cycle.
    always_comb begin
        acc_cycle = 1'b0;
        case (state)
            RUN:     acc_cycle = (tap != ADDR_ZERO);
            DRAIN:   acc_cycle = 1'b1;
            default: acc_cycle = 1'b0;
        endcase
`ifdef PE_ZERO_GATE_EN
        gate = acc_cycle && (ifmap_data == DATA_ZERO);
`else
        gate = 1'b0;
`endif
        acc_write = acc_cycle && !gate;
        if (acc_write) begin
            mult_in1 = filt_data;
            mult_in2 = ifmap_data;
            acc_next = acc + PSUM_WIDTH'(mult_out);
        end else begin
            mult_in1 = DATA_ZERO;
            mult_in2 = DATA_ZERO;
            acc_next = acc;
        end
    end

    // Row datapath: operand latch, tap walk, accumulator and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_len       <= ADDR_ZERO;
            tap         <= ADDR_ZERO;
            acc         <= PSUM_ZERO;
            filt_rd_en  <= 1'b0;
            ifmap_rd_en <= 1'b0;
            filt_addr   <= ADDR_ZERO;
            ifmap_addr  <= ADDR_ZERO;
            psum_out    <= PSUM_ZERO;
            psum_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_len       <= filt_len;
                        tap         <= ADDR_ZERO;
                        acc         <= psum_in;
                        filt_rd_en  <= (filt_len != ADDR_ZERO);
                        ifmap_rd_en <= (filt_len != ADDR_ZERO);
                        filt_addr   <= ADDR_ZERO;
                        ifmap_addr  <= ifmap_base;
                        // An empty row completes straight away with psum_in.
                        if (filt_len == ADDR_ZERO) begin
                            psum_out   <= psum_in;
                            psum_valid <= 1'b1;
                        end else begin
                            psum_valid <= 1'b0;
                        end
                    end else begin
                        psum_valid <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last_tap) begin
                        filt_rd_en  <= 1'b0;
                        ifmap_rd_en <= 1'b0;
                        filt_addr   <= ADDR_ZERO;
                        ifmap_addr  <= ADDR_ZERO;
                    end else begin
                        tap         <= tap + ADDR_ONE;
                        filt_addr   <= tap + ADDR_ONE;
                        // Natural ADDR_WIDTH overflow gives the modular wrap.
                        ifmap_addr  <= ifmap_addr + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    acc        <= acc_next;
                    psum_out   <= acc_next;
                    psum_valid <= 1'b1;
                end
                DONE: begin
                    if (psum_ready) begin
                        psum_valid <= 1'b0;
                    end else begin
                        psum_valid <= 1'b1;
                    end
                end
                default: begin
                    psum_valid <= 1'b0;
                end
            endcase
        end
    end

    // Busy flag, registered from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
        end
    end

`ifdef PE_ZERO_GATE_EN
    // Gated-tap counter: cleared on an accepted start, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_skips <= ADDR_ZERO;
        end else if ((state == IDLE) && start) begin
            zero_skips <= ADDR_ZERO;
        end else if (gate && (zero_skips != ADDR_MAX)) begin
            zero_skips <= zero_skips + ADDR_ONE;
        end else begin
            zero_skips <= zero_skips;
        end
    end
`else
    assign zero_skips = ADDR_ZERO;
`endif

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pe_mac_sequencer
// Directed scoreboard bench for pe_mac_sequencer. The driver loads the spad
// models, issues rows and pushes the expected psum/zero_skips/latency, the
// expected spad addresses and the expected multiplier operand pairs into
// queues. An independent monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_pe_mac_sequencer;

    localparam int DW = 8;
    localparam int PW = 16;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   filt_len = '0;
    logic [AW-1:0]   ifmap_base = '0;
    logic [PW-1:0]   psum_in = '0;
    logic            busy;
    logic            filt_rd_en, ifmap_rd_en;
    logic [AW-1:0]   filt_addr, ifmap_addr;
    logic [DW-1:0]   filt_data = '0, ifmap_data = '0;
    logic [DW-1:0]   mult_in1, mult_in2;
    logic [2*DW-1:0] mult_out;
    logic [PW-1:0]   psum_out;
    logic            psum_valid;
    logic            psum_ready = 1'b1;
    logic [AW-1:0]   zero_skips;

    pe_mac_sequencer #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .filt_len(filt_len),
        .ifmap_base(ifmap_base), .psum_in(psum_in), .busy(busy),
        .filt_rd_en(filt_rd_en), .ifmap_rd_en(ifmap_rd_en),
        .filt_addr(filt_addr), .ifmap_addr(ifmap_addr),
        .filt_data(filt_data), .ifmap_data(ifmap_data),
        .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_out(mult_out),
        .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .zero_skips(zero_skips)
    );

    always #5 clk = ~clk;

    // Combinational multiplier and 1-cycle-latency spads
    assign mult_out = {8'h00, mult_in1} * {8'h00, mult_in2};
    logic [DW-1:0] filt_mem  [16];
    logic [DW-1:0] ifmap_mem [16];
    always @(posedge clk) begin
        if (filt_rd_en)  filt_data  <= filt_mem[filt_addr];
        if (ifmap_rd_en) ifmap_data <= ifmap_mem[ifmap_addr];
    end

    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] psum;
        logic [AW-1:0] zs;
        int            lat;
    } exp_t;

    exp_t            exp_q[$];
    logic [2*AW-1:0] addr_q[$];
    logic [2*DW-1:0] pair_q[$];

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor / scoreboard
    logic prev_rd = 1'b0, prev_valid = 1'b0, after_hs = 1'b0;
    always @(negedge clk) begin
        logic [2*AW-1:0] a;
        logic [2*DW-1:0] p;
        if (reset) begin
            prev_rd = 1'b0; prev_valid = 1'b0; after_hs = 1'b0;
        end else begin
            if (after_hs) begin
                chk("busy_after_hs", 32'(busy), 32'd0);
                chk("valid_after_hs", 32'(psum_valid), 32'd0);
                after_hs = 1'b0;
            end
            if (filt_rd_en || ifmap_rd_en) begin
                if (addr_q.size() == 0) flag("unexpected_rd");
                else begin
                    a = addr_q.pop_front();
                    chk("rd_en_pair", 32'({filt_rd_en, ifmap_rd_en}), 32'd3);
                    chk("filt_addr", 32'(filt_addr), 32'(a[2*AW-1:AW]));
                    chk("ifmap_addr", 32'(ifmap_addr), 32'(a[AW-1:0]));
                end
            end
            if (prev_rd) begin
                if (pair_q.size() == 0) flag("unexpected_acc");
                else begin
                    p = pair_q.pop_front();
                    chk("mult_in1", 32'(mult_in1), 32'(p[2*DW-1:DW]));
                    chk("mult_in2", 32'(mult_in2), 32'(p[DW-1:0]));
                end
            end else begin
                chk("mult_idle", 32'({mult_in1, mult_in2}), 32'd0);
            end
            prev_rd = filt_rd_en;
            if (psum_valid) begin
                if (exp_q.size() == 0) flag("unexpected_valid");
                else begin
                    if (!prev_valid) chk("latency", 32'(cyc - t0 + 1), 32'(exp_q[0].lat));
                    chk("busy_while_valid", 32'(busy), 32'd1);
                    chk("psum_out", 32'(psum_out), 32'(exp_q[0].psum));
                    if (psum_ready) begin
                        chk("zero_skips", 32'(zero_skips), 32'(exp_q[0].zs));
                        void'(exp_q.pop_front());
                        after_hs = 1'b1;
                    end
                end
            end
            prev_valid = psum_valid;
        end
    end

    task automatic flush();
        exp_q.delete(); addr_q.delete(); pair_q.delete();
    endtask

    // Issue one row; expected psum and zero_skips are hand-computed by caller
    task automatic issue(input int n, input int base, input int pin,
                         input int exp_psum, input int exp_zs);
        logic [AW-1:0] ia;
        logic [2*DW-1:0] pr;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            ia = AW'(base + k);
            addr_q.push_back({AW'(k), ia});
            pr = {filt_mem[k], ifmap_mem[ia]};
`ifdef PE_ZERO_GATE_EN
            if (ifmap_mem[ia] == 8'd0) pr = 16'd0;
`endif
            pair_q.push_back(pr);
        end
        e.psum = PW'(exp_psum);
        e.zs   = AW'(exp_zs);
        e.lat  = n + 2;
        if (n == 0) e.lat = 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        filt_len = AW'(n); ifmap_base = AW'(base); psum_in = PW'(pin); start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            flag("timeout");
            flush();
        end
        @(posedge clk);
    endtask

    task automatic fill(input int fv, input int iv);
        for (int i = 0; i < 16; i++) begin
            filt_mem[i] = DW'(fv);
            ifmap_mem[i] = DW'(iv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_en"}, 32'({filt_rd_en, ifmap_rd_en}), 32'd0);
        chk({tag, "_addr"}, 32'({filt_addr, ifmap_addr}), 32'd0);
        chk({tag, "_mult_in"}, 32'({mult_in1, mult_in2}), 32'd0);
        chk({tag, "_psum_out"}, 32'(psum_out), 32'd0);
        chk({tag, "_psum_valid"}, 32'(psum_valid), 32'd0);
        chk({tag, "_zero_skips"}, 32'(zero_skips), 32'd0);
    endtask

    initial begin
        fill(0, 0);
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic row: 5 + 2*10 + 3*20 + 4*30 = 205
        fill(0, 0);
        filt_mem[0] = 8'd2; filt_mem[1] = 8'd3; filt_mem[2] = 8'd4;
        ifmap_mem[0] = 8'd10; ifmap_mem[1] = 8'd20; ifmap_mem[2] = 8'd30;
        issue(3, 0, 5, 205, 0);
        wait_done(50);

        // Empty row returns psum_in after one cycle
        issue(0, 0, 77, 77, 0);
        wait_done(20);

        // Backpressure: 100 + 1*7 + 2*8 = 123, ifmap base 3
        fill(0, 0);
        filt_mem[0] = 8'd1; filt_mem[1] = 8'd2;
        ifmap_mem[3] = 8'd7; ifmap_mem[4] = 8'd8;
        psum_ready = 1'b0;
        issue(2, 3, 100, 123, 0);
        for (int i = 0; i < 20 && !psum_valid; i++) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = (i % 2 == 0);
        end
        @(posedge clk); #1;
        psum_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20);

        // Address wrap: base 14, n=4 -> 1*3 + 1*4 + 1*5 + 1*6 = 18
        fill(1, 0);
        ifmap_mem[14] = 8'd3; ifmap_mem[15] = 8'd4; ifmap_mem[0] = 8'd5; ifmap_mem[1] = 8'd6;
        issue(4, 14, 0, 18, 0);
        wait_done(50);

        // Overflow: 0xFFFF + 1*1 wraps to 0
        fill(1, 1);
        issue(1, 0, 65535, 0, 0);
        wait_done(20);

        // Largest product: 1000 + 255*255 = 66025 -> 489 mod 2^16
        fill(255, 255);
        issue(1, 0, 1000, 489, 0);
        wait_done(20);

        // Longest row, 15 taps, ifmap wraps from base 5: 3 + 15*2 = 33
        fill(1, 2);
        issue(15, 5, 3, 33, 0);
        wait_done(60);

        // Reset in RUN at tap 2 discards the row
        fill(1, 1);
        issue(4, 0, 0, 4, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (filt_rd_en && filt_addr == 4'd2) break;
        end
        chk("reached_tap2", 32'(filt_addr), 32'd2);
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        flush();
        @(posedge clk); #1;
        reset = 1'b0;

        // Fresh row after reset
        fill(0, 0);
        filt_mem[0] = 8'd2; filt_mem[1] = 8'd3; filt_mem[2] = 8'd4;
        ifmap_mem[0] = 8'd10; ifmap_mem[1] = 8'd20; ifmap_mem[2] = 8'd30;
        issue(3, 0, 5, 205, 0);
        wait_done(50);

        // Zero operands: 50 + 9*0 + 2*5 + 9*0 = 60 in both builds
        fill(0, 0);
        filt_mem[0] = 8'd9; filt_mem[1] = 8'd2; filt_mem[2] = 8'd9;
        ifmap_mem[0] = 8'd0; ifmap_mem[1] = 8'd5; ifmap_mem[2] = 8'd0;
`ifdef PE_ZERO_GATE_EN
        issue(3, 0, 50, 60, 2);
`else
        issue(3, 0, 50, 60, 0);
`endif
        wait_done(50);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mac_sequencer.md
# pe_mac_sequencer

Sequences the PE's shared unsigned Wallace-tree multiplier through one 1-D convolution row. It walks the filter and ifmap scratchpads tap by tap and feeds each operand pair to the multiplier. Products are accumulated onto an incoming partial sum, and the finished psum is returned over a valid/ready handshake. It sits between the PE control FSM and the spad/multiplier datapath, and is the only driver of the multiplier operands.

## Interface
- DATA_WIDTH, 8, width of filter and ifmap words; multiplier is DATA_WIDTH x DATA_WIDTH
- PSUM_WIDTH, 20, accumulator and psum width (>= 2*DATA_WIDTH)
- ADDR_WIDTH, 4, spad address width; max taps 2^ADDR_WIDTH-1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; accepted only in IDLE
- filt_len  input  ADDR_WIDTH  number of taps n, sampled on accepted start
- ifmap_base  input  ADDR_WIDTH  ifmap start address, sampled on accepted start
- psum_in  input  PSUM_WIDTH  initial accumulator value, sampled on accepted start
- busy  output  1  high in every state except IDLE
- filt_rd_en, ifmap_rd_en  output  1 each  spad read strobes
- filt_addr, ifmap_addr  output  ADDR_WIDTH each  spad read addresses
- filt_data, ifmap_data  input  DATA_WIDTH each  spad read data, valid 1 cycle after rd_en
- mult_in1, mult_in2  output  DATA_WIDTH each  multiplier operands (filter, ifmap)
- mult_out  input  2*DATA_WIDTH  combinational multiplier product
- psum_out  output  PSUM_WIDTH  final partial sum, registered
- psum_valid  output  1  psum_out valid
- psum_ready  input  1  consumer accepts psum_out
- zero_skips  output  ADDR_WIDTH  gated taps in the current/last row

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + start: latch n, ifmap_base, and acc<=psum_in; clear tap counter and zero_skips. Go to RUN if n!=0, else DONE.
- RUN, tap k = 0..n-1, one cycle each: filt_rd_en = ifmap_rd_en = 1, filt_addr = k, ifmap_addr = (ifmap_base + k) mod 2^ADDR_WIDTH (wraps). After tap n-1, go to DRAIN.
- Accumulate cycle: every RUN cycle with k>0, plus the DRAIN cycle, has an accumulate step.
  - mult_in1 = filt_data, mult_in2 = ifmap_data.
  - acc <= (acc + zero-extended mult_out) mod 2^PSUM_WIDTH.
  - Unsigned arithmetic; overflow silently wraps.
- mult_in1/mult_in2 are 0 in all non-accumulate cycles.
- DRAIN: performs the last accumulate, loads psum_out with the final acc, sets psum_valid, and goes to DONE.
- n=0: psum_out <= psum_in and psum_valid set on the cycle leaving IDLE.
- DONE: hold psum_out/psum_valid until psum_valid && psum_ready; then clear psum_valid and go to IDLE.
- start outside IDLE is ignored, including a start in the same cycle as the DONE handshake.
- Reset (async, any state) clears every output to 0 and returns to IDLE: busy, rd_ens, addresses, mult_in*, psum_out, psum_valid, zero_skips. Any in-flight row is discarded.

## Timing
- Start accepted at edge E0. RUN occupies cycles 1..n, DRAIN cycle n+1, psum_valid high from cycle n+2.
- Start-to-psum_valid latency: n+2 cycles; n=0 gives 1 cycle.
- Spad read latency fixed at 1 cycle; the multiplier is combinational within the accumulate cycle.
- Earliest next start: the cycle after the handshake, giving a throughput of n+3 cycles per row.
- busy rises the cycle after an accepted start and falls the cycle after the handshake.

## Configuration
- PE_ZERO_GATE_EN defined:
  - In an accumulate cycle with ifmap_data==0, mult_in1/mult_in2 are forced to 0.
  - The acc write is suppressed.
  - zero_skips increments, saturating at 2^ADDR_WIDTH-1.
- PE_ZERO_GATE_EN undefined: no gating; zero_skips is tied to 0. psum_out is identical in both builds.

## Test plan
- n=3, psum_in=5, filt={2,3,4}, ifmap(base 0)={10,20,30} -> psum_valid at cycle 5, psum_out=205; mult_in pairs (2,10),(3,20),(4,30) on cycles 2,3,4.
- n=0, psum_in=77 -> psum_valid 1 cycle after start, psum_out=77, no rd_en pulses.
- Backpressure: psum_ready low 4 cycles after psum_valid -> psum_out stable, busy stays high, start pulses ignored; handshake returns to IDLE next cycle.
- Wrap: ifmap_base=14, n=4 -> ifmap_addr 14,15,0,1. Overflow: PSUM_WIDTH=16, psum_in=0xFFFF, one tap 1x1 -> psum_out=0x0000.
- Reset asserted in RUN at tap 2 -> all outputs 0 immediately; a fresh start then produces the correct result.
- PE_ZERO_GATE_EN: ifmap={0,5,0}, filt={9,2,9} -> psum_out=psum_in+10, zero_skips=2, mult_in=0 on gated cycles; macro undefined -> same psum_out, zero_skips=0.
